// File: rtl/ysyx_22050019_mem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
// Holds the FSM state encoding, the owner encoding and the default widths
// used by ysyx_22050019_mem_arbiter and ysyx_22050019_mem_arb_pick.
package ysyx_22050019_mem_arbiter_pkg;

    localparam int AW_DEF = 64;
    localparam int DW_DEF = 64;

    // FSM state encoding
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    // Owner of the in-flight transaction
    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_LSU = 1'b1;

endpackage

// File: rtl/ysyx_22050019_mem_arb_pick.sv
// Grant decision and IF starvation guard for the memory arbiter.
// Ports:
//   clk, rst_n         clock / asynchronous active-low reset
//   if_valid           fetch request pending
//   lsu_valid          load/store request pending
//   idle               arbiter FSM is in IDLE and may grant
//   grant_if/grant_lsu one-hot combinational grant (both 0 when not idle)
// LSU has fixed priority unless IF has been waiting through STARVE_MAX
// consecutive LSU grants, in which case IF is forced to win once.
module ysyx_22050019_mem_arb_pick #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic if_valid,
    input  logic lsu_valid,
    input  logic idle,
    output logic grant_if,
    output logic grant_lsu
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

    logic [CW-1:0] starve_cnt_q;
    logic [CW-1:0] starve_cnt_d;
    logic          if_forced_s;

    // Grant decision: LSU first unless IF has hit the starvation limit
    always_comb begin
        if_forced_s = if_valid && (starve_cnt_q == CNT_MAX);
        grant_lsu   = idle && lsu_valid && !if_forced_s;
        grant_if    = idle && if_valid && !grant_lsu;
    end

    // Starvation counter next value; it only counts while IF keeps waiting
    always_comb begin
        if (!if_valid) begin
            starve_cnt_d = {CW{1'b0}};
        end else if (grant_if) begin
            starve_cnt_d = {CW{1'b0}};
        end else if (grant_lsu && (starve_cnt_q != CNT_MAX)) begin
            starve_cnt_d = starve_cnt_q + CW'(1);
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    // Starvation counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= {CW{1'b0}};
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/ysyx_22050019_mem_arbiter.sv
// Data-memory arbiter between instruction fetch (IF) and load/store (LSU).
// One transaction outstanding at a time: IDLE grants, REQ presents the
// latched request until mem_req_ready, WAIT collects the response (or times
// out after TIMEOUT_CYC cycles), RESP pulses the owner's resp_valid once.
// Ports:
//   if_*   fetch request/response (reads only)
//   lsu_*  load/store request/response (stores also get a response)
//   mem_*  single shared memory port
module ysyx_22050019_mem_arbiter
    import ysyx_22050019_mem_arbiter_pkg::*;
#(
    parameter int AW          = AW_DEF,
    parameter int DW          = DW_DEF,
    parameter int STARVE_MAX  = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_req_valid,
    output logic            if_req_ready,
    input  logic [AW-1:0]   if_addr,
    output logic            if_resp_valid,
    output logic            if_resp_err,
    output logic [DW-1:0]   if_rdata,
    input  logic            lsu_req_valid,
    output logic            lsu_req_ready,
    input  logic            lsu_wen,
    input  logic [AW-1:0]   lsu_addr,
    input  logic [DW-1:0]   lsu_wdata,
    input  logic [DW/8-1:0] lsu_mask,
    output logic            lsu_resp_valid,
    output logic            lsu_resp_err,
    output logic [DW-1:0]   lsu_rdata,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic            mem_wen,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_mask,
    input  logic            mem_resp_valid,
    input  logic [DW-1:0]   mem_rdata
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYC);

    logic [1:0]      state_q, state_d;
    logic            owner_q, owner_d;
    logic            wen_q, wen_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW/8-1:0] mask_q, mask_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [DW-1:0]   if_rdata_q, if_rdata_d;
    logic [DW-1:0]   lsu_rdata_q, lsu_rdata_d;
    logic            if_resp_valid_q, if_resp_valid_d;
    logic            if_resp_err_q, if_resp_err_d;
    logic            lsu_resp_valid_q, lsu_resp_valid_d;
    logic            lsu_resp_err_q, lsu_resp_err_d;

    logic            grant_if_s, grant_lsu_s, idle_s;
    logic [TW-1:0]   tcnt_inc_s;
    logic            resp_fire_s, resp_err_s;
    logic [DW-1:0]   resp_data_s;

    assign idle_s = (state_q == S_IDLE);

    ysyx_22050019_mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_valid  (if_req_valid),
        .lsu_valid (lsu_req_valid),
        .idle      (idle_s),
        .grant_if  (grant_if_s),
        .grant_lsu (grant_lsu_s)
    );

    // FSM, request latching and WAIT-exit detection
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        wen_d       = wen_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mask_d      = mask_q;
        tcnt_d      = tcnt_q;
        tcnt_inc_s  = tcnt_q + TW'(1);
        resp_fire_s = 1'b0;
        resp_err_s  = 1'b0;
        resp_data_s = {DW{1'b0}};
        case (state_q)
            S_IDLE: begin
                if (grant_lsu_s) begin
                    owner_d = OWN_LSU;
                    wen_d   = lsu_wen;
                    addr_d  = lsu_addr;
                    wdata_d = lsu_wdata;
                    mask_d  = lsu_mask;
                    state_d = S_REQ;
                end else if (grant_if_s) begin
                    // Fetches are always full-width reads
                    owner_d = OWN_IF;
                    wen_d   = 1'b0;
                    addr_d  = if_addr;
                    wdata_d = {DW{1'b0}};
                    mask_d  = {(DW/8){1'b1}};
                    state_d = S_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    state_d = S_WAIT;
                    tcnt_d  = {TW{1'b0}};
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                // A real response beats a timeout landing in the same cycle
                if (mem_resp_valid) begin
                    resp_fire_s = 1'b1;
                    resp_data_s = mem_rdata;
                    state_d     = S_RESP;
                end else if (tcnt_inc_s == T_MAX) begin
                    resp_fire_s = 1'b1;
                    resp_err_s  = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    tcnt_d = tcnt_inc_s;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Response routing: only the owner's data register is updated
    always_comb begin
        if_rdata_d       = if_rdata_q;
        lsu_rdata_d      = lsu_rdata_q;
        if_resp_valid_d  = 1'b0;
        if_resp_err_d    = 1'b0;
        lsu_resp_valid_d = 1'b0;
        lsu_resp_err_d   = 1'b0;
        if (resp_fire_s) begin
            if (owner_q == OWN_LSU) begin
                lsu_rdata_d      = resp_data_s;
                lsu_resp_valid_d = 1'b1;
                lsu_resp_err_d   = resp_err_s;
            end else begin
                if_rdata_d       = resp_data_s;
                if_resp_valid_d  = 1'b1;
                if_resp_err_d    = resp_err_s;
            end
        end else begin
            if_resp_valid_d  = 1'b0;
            lsu_resp_valid_d = 1'b0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            owner_q          <= OWN_IF;
            wen_q            <= 1'b0;
            addr_q           <= {AW{1'b0}};
            wdata_q          <= {DW{1'b0}};
            mask_q           <= {(DW/8){1'b0}};
            tcnt_q           <= {TW{1'b0}};
            if_rdata_q       <= {DW{1'b0}};
            lsu_rdata_q      <= {DW{1'b0}};
            if_resp_valid_q  <= 1'b0;
            if_resp_err_q    <= 1'b0;
            lsu_resp_valid_q <= 1'b0;
            lsu_resp_err_q   <= 1'b0;
        end else begin
            state_q          <= state_d;
            owner_q          <= owner_d;
            wen_q            <= wen_d;
            addr_q           <= addr_d;
            wdata_q          <= wdata_d;
            mask_q           <= mask_d;
            tcnt_q           <= tcnt_d;
            if_rdata_q       <= if_rdata_d;
            lsu_rdata_q      <= lsu_rdata_d;
            if_resp_valid_q  <= if_resp_valid_d;
            if_resp_err_q    <= if_resp_err_d;
            lsu_resp_valid_q <= lsu_resp_valid_d;
            lsu_resp_err_q   <= lsu_resp_err_d;
        end
    end

    assign if_req_ready   = grant_if_s;
    assign lsu_req_ready  = grant_lsu_s;
    assign if_resp_valid  = if_resp_valid_q;
    assign if_resp_err    = if_resp_err_q;
    assign if_rdata       = if_rdata_q;
    assign lsu_resp_valid = lsu_resp_valid_q;
    assign lsu_resp_err   = lsu_resp_err_q;
    assign lsu_rdata      = lsu_rdata_q;
    assign mem_req_valid  = (state_q == S_REQ);
    assign mem_wen        = wen_q;
    assign mem_addr       = addr_q;
    assign mem_wdata      = wdata_q;
    assign mem_mask       = mask_q;

endmodule

// File: tb/tb_ysyx_22050019_mem_arbiter.sv
// Directed bench for ysyx_22050019_mem_arbiter with a small memory model and
// a response scoreboard (expected responses queued when stimulus is driven).
module tb_ysyx_22050019_mem_arbiter;
    import ysyx_22050019_mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req_valid, if_req_ready, if_resp_valid, if_resp_err;
    logic [63:0] if_addr, if_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_err;
    logic [63:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [7:0]  lsu_mask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_mask;

    typedef struct {
        logic        own;
        logic [63:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    logic grant_log[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // memory model controls
    logic        mem_ready_en;
    logic        mem_mute;
    logic        force_resp;
    int          resp_delay;
    int          cd;
    logic [63:0] pend_addr;
    logic        model_resp;
    logic [63:0] model_rdata;

    always #5 clk = ~clk;

    ysyx_22050019_mem_arbiter #(
        .AW(64), .DW(64), .STARVE_MAX(4), .TIMEOUT_CYC(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_resp_valid(if_resp_valid), .if_resp_err(if_resp_err), .if_rdata(if_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_mask(lsu_mask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_err(lsu_resp_err), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mask(mem_mask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    function automatic logic [63:0] mem_val(input logic [63:0] a);
        if (a == 64'h8000_0000) return 64'h0000_0413;
        else return ~a;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic expect_resp(input logic own, input logic [63:0] data, input logic err);
        exp_t e;
        e.own  = own;
        e.data = data;
        e.err  = err;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string tag, input int max);
        for (int i = 0; i < max && sb.size() != 0; i++) @(negedge clk);
        chk({"drain_", tag}, 64'(sb.size()), 64'd0);
    endtask

    // Memory model: accepts when mem_ready_en, answers resp_delay cycles later
    assign mem_req_ready  = mem_ready_en;
    assign mem_resp_valid = model_resp | force_resp;
    assign mem_rdata      = model_resp ? model_rdata : 64'hBAD0_BAD0_BAD0_BAD0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cd          <= 0;
            model_resp  <= 1'b0;
            model_rdata <= 64'd0;
            pend_addr   <= 64'd0;
        end else begin
            model_resp <= 1'b0;
            if (mem_req_valid && mem_req_ready) begin
                if (resp_delay == 1) begin
                    model_resp  <= !mem_mute;
                    model_rdata <= mem_val(mem_addr);
                end else begin
                    cd        <= resp_delay - 1;
                    pend_addr <= mem_addr;
                end
            end else if (cd > 0) begin
                cd <= cd - 1;
                if (cd == 1) begin
                    model_resp  <= !mem_mute;
                    model_rdata <= mem_val(pend_addr);
                end
            end
        end
    end

    // Monitor: log grants and score every response pulse
    always @(negedge clk) begin
        exp_t e;
        if (if_req_ready)  grant_log.push_back(OWN_IF);
        if (lsu_req_ready) grant_log.push_back(OWN_LSU);
        if (if_resp_valid || lsu_resp_valid) begin
            chk("resp_onehot", 64'(if_resp_valid & lsu_resp_valid), 64'd0);
            if (sb.size() == 0) begin
                chk("unexpected_resp", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_owner", 64'(lsu_resp_valid), 64'(e.own));
                chk("sb_data", lsu_resp_valid ? lsu_rdata : if_rdata, e.data);
                chk("sb_err", 64'(lsu_resp_valid ? lsu_resp_err : if_resp_err), 64'(e.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; if_req_valid = 1'b0; if_addr = 64'd0;
        lsu_req_valid = 1'b0; lsu_wen = 1'b0; lsu_addr = 64'd0; lsu_wdata = 64'd0; lsu_mask = 8'd0;
        mem_ready_en = 1'b1; mem_mute = 1'b0; force_resp = 1'b0; resp_delay = 1;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_if_ready", 64'(if_req_ready), 64'd0);
        chk("rst_lsu_ready", 64'(lsu_req_ready), 64'd0);
        chk("rst_mem_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_mem_mask", 64'(mem_mask), 64'd0);
        chk("rst_resp", 64'({if_resp_valid, lsu_resp_valid, if_resp_err, lsu_resp_err}), 64'd0);
        step(); rst_n = 1'b1;
        repeat (2) step();

        // single IF fetch: 4-cycle latency
        if_addr = 64'h8000_0000; if_req_valid = 1'b1;
        expect_resp(OWN_IF, 64'h0000_0413, 1'b0);
        @(negedge clk);
        chk("t1_if_ready_c0", 64'(if_req_ready), 64'd1);
        chk("t1_lsu_ready_c0", 64'(lsu_req_ready), 64'd0);
        step(); if_req_valid = 1'b0;
        @(negedge clk);
        chk("t1_mem_valid_c1", 64'(mem_req_valid), 64'd1);
        chk("t1_mem_addr_c1", mem_addr, 64'h8000_0000);
        chk("t1_mem_wen_c1", 64'(mem_wen), 64'd0);
        chk("t1_mem_mask_c1", 64'(mem_mask), 64'hFF);
        @(negedge clk);
        chk("t1_no_resp_c2", 64'(if_resp_valid), 64'd0);
        @(negedge clk);
        chk("t1_resp_c3", 64'(if_resp_valid), 64'd1);
        chk("t1_rdata_c3", if_rdata, 64'h0000_0413);
        chk("t1_err_c3", 64'(if_resp_err), 64'd0);
        wait_drain("t1", 10);
        repeat (2) step();

        // collision: LSU store wins, IF granted in the following IDLE
        if_req_valid = 1'b1; if_addr = 64'h8000_0004;
        lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 64'h8000_1000;
        lsu_wdata = 64'hDEAD_BEEF; lsu_mask = 8'h0F;
        expect_resp(OWN_LSU, mem_val(64'h8000_1000), 1'b0);
        expect_resp(OWN_IF, mem_val(64'h8000_0004), 1'b0);
        @(negedge clk);
        chk("t2_lsu_ready_c0", 64'(lsu_req_ready), 64'd1);
        chk("t2_if_ready_c0", 64'(if_req_ready), 64'd0);
        step(); lsu_req_valid = 1'b0; lsu_wen = 1'b0;
        @(negedge clk);
        chk("t2_mem_mask", 64'(mem_mask), 64'h0F);
        chk("t2_mem_wen", 64'(mem_wen), 64'd1);
        chk("t2_mem_wdata", mem_wdata, 64'hDEAD_BEEF);
        chk("t2_mem_addr", mem_addr, 64'h8000_1000);
        @(negedge clk);
        @(negedge clk);
        chk("t2_lsu_resp_c3", 64'(lsu_resp_valid), 64'd1);
        chk("t2_if_ready_c3", 64'(if_req_ready), 64'd0);
        @(negedge clk);
        chk("t2_if_ready_c4", 64'(if_req_ready), 64'd1);
        step(); if_req_valid = 1'b0;
        wait_drain("t2", 20);
        chk("t2_lsu_rdata_held", lsu_rdata, mem_val(64'h8000_1000));
        repeat (2) step();

        // starvation guard: LSU x4 then IF, repeating
        grant_log.delete();
        if_req_valid = 1'b1; if_addr = 64'h8000_0100;
        lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 64'h8000_2000; lsu_mask = 8'hFF; lsu_wdata = 64'd0;
        for (int i = 0; i < 10; i++) begin
            if (i % 5 == 4) expect_resp(OWN_IF, mem_val(64'h8000_0100), 1'b0);
            else expect_resp(OWN_LSU, mem_val(64'h8000_2000), 1'b0);
        end
        for (int i = 0; i < 200 && grant_log.size() < 10; i++) @(negedge clk);
        step(); if_req_valid = 1'b0; lsu_req_valid = 1'b0;
        chk("t3_grant_count", 64'(grant_log.size()), 64'd10);
        for (int i = 0; i < 10 && i < grant_log.size(); i++)
            chk($sformatf("t3_order_%0d", i), 64'(grant_log[i]), (i % 5 == 4) ? 64'(OWN_IF) : 64'(OWN_LSU));
        wait_drain("t3", 40);
        repeat (2) step();

        // stall: memory not ready for 5 cycles
        mem_ready_en = 1'b0;
        lsu_req_valid = 1'b1; lsu_addr = 64'h8000_3000;
        expect_resp(OWN_LSU, mem_val(64'h8000_3000), 1'b0);
        expect_resp(OWN_IF, mem_val(64'h8000_0200), 1'b0);
        @(negedge clk);
        chk("t4_lsu_ready_c0", 64'(lsu_req_ready), 64'd1);
        step(); lsu_req_valid = 1'b0; if_req_valid = 1'b1; if_addr = 64'h8000_0200;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("t4_valid_c%0d", k), 64'(mem_req_valid), 64'd1);
            chk($sformatf("t4_addr_c%0d", k), mem_addr, 64'h8000_3000);
            chk($sformatf("t4_no_grant_c%0d", k), 64'(if_req_ready), 64'd0);
        end
        step(); mem_ready_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t4_no_resp_c7", 64'(lsu_resp_valid), 64'd0);
        @(negedge clk);
        chk("t4_resp_c8", 64'(lsu_resp_valid), 64'd1);
        for (int i = 0; i < 10 && !if_req_ready; i++) @(negedge clk);
        chk("t4_if_grant", 64'(if_req_ready), 64'd1);
        step(); if_req_valid = 1'b0;
        wait_drain("t4", 20);
        repeat (2) step();

        // timeout: no memory response, error 8 cycles after WAIT entry
        mem_mute = 1'b1;
        lsu_req_valid = 1'b1; lsu_addr = 64'h8000_4000;
        expect_resp(OWN_LSU, 64'd0, 1'b1);
        @(negedge clk);
        chk("t5_lsu_ready_c0", 64'(lsu_req_ready), 64'd1);
        step(); lsu_req_valid = 1'b0;
        @(negedge clk);
        chk("t5_mem_valid_c1", 64'(mem_req_valid), 64'd1);
        for (int k = 2; k <= 9; k++) begin
            @(negedge clk);
            chk($sformatf("t5_no_resp_c%0d", k), 64'(lsu_resp_valid), 64'd0);
        end
        @(negedge clk);
        chk("t5_resp_c10", 64'(lsu_resp_valid), 64'd1);
        chk("t5_err_c10", 64'(lsu_resp_err), 64'd1);
        chk("t5_rdata_c10", lsu_rdata, 64'd0);
        step(); force_resp = 1'b1;
        @(negedge clk);
        chk("t5_late_ignored", 64'({lsu_resp_valid, if_resp_valid, mem_req_valid}), 64'd0);
        step();
        @(negedge clk);
        chk("t5_late_no_resp", 64'({lsu_resp_valid, if_resp_valid}), 64'd0);
        step(); force_resp = 1'b0; mem_mute = 1'b0;
        repeat (2) step();

        // reset while in WAIT: everything drops, no response
        resp_delay = 5;
        if_req_valid = 1'b1; if_addr = 64'h8000_5000;
        @(negedge clk);
        chk("t6_if_ready_c0", 64'(if_req_ready), 64'd1);
        step(); if_req_valid = 1'b0;
        @(negedge clk);
        chk("t6_mem_valid_c1", 64'(mem_req_valid), 64'd1);
        @(negedge clk);
        chk("t6_no_resp_c2", 64'(if_resp_valid), 64'd0);
        step(); rst_n = 1'b0; #1;
        chk("t6_rst_mem_valid", 64'(mem_req_valid), 64'd0);
        chk("t6_rst_mem_addr", mem_addr, 64'd0);
        chk("t6_rst_if_rdata", if_rdata, 64'd0);
        chk("t6_rst_ready", 64'({if_req_ready, lsu_req_ready}), 64'd0);
        chk("t6_rst_resp", 64'({if_resp_valid, lsu_resp_valid, if_resp_err, lsu_resp_err}), 64'd0);
        step(); rst_n = 1'b1; resp_delay = 1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("t6_quiet_%0d", k), 64'({if_resp_valid, mem_req_valid}), 64'd0);
        end
        step();
        lsu_req_valid = 1'b1; lsu_addr = 64'h8000_6000;
        expect_resp(OWN_LSU, mem_val(64'h8000_6000), 1'b0);
        for (int i = 0; i < 10 && !lsu_req_ready; i++) @(negedge clk);
        chk("t6_lsu_grant", 64'(lsu_req_ready), 64'd1);
        step(); lsu_req_valid = 1'b0;
        wait_drain("t6", 20);
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ysyx_22050019_mem_arbiter.md
Name: ysyx_22050019_mem_arbiter

Overview:
- Shares the single data-memory port between instruction fetch (IF) and load/store (LSU) requesters.
- Sits between the fetch stage, the LSU and the memory model/bus.
- Serialises accesses with one outstanding transaction, fixed LSU priority and an IF starvation guard.
- Routes each response to its owner and detects a hung memory with a timeout.

Parameters:
- AW, 64, address width
- DW, 64, data width
- STARVE_MAX, 4, consecutive LSU grants allowed while IF waits before IF is forced to win (>=1)
- TIMEOUT_CYC, 255, maximum cycles in WAIT before an error response

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch request accepted this cycle
- if_addr  in  AW  fetch address
- if_resp_valid  out  1  fetch response pulse
- if_resp_err  out  1  fetch timed out (qualified by if_resp_valid)
- if_rdata  out  DW  fetch read data
- lsu_req_valid  in  1  load/store request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_wen  in  1  1 = store
- lsu_addr  in  AW  LSU address
- lsu_wdata  in  DW  store data
- lsu_mask  in  DW/8  byte-enable mask
- lsu_resp_valid  out  1  LSU response pulse (loads and stores)
- lsu_resp_err  out  1  LSU timed out
- lsu_rdata  out  DW  load data
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_wen  out  1  write enable
- mem_addr  out  AW  address
- mem_wdata  out  DW  write data
- mem_mask  out  DW/8  byte mask
- mem_resp_valid  in  1  memory response
- mem_rdata  in  DW  memory read data

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE; all *_ready, *_valid and *_err outputs 0; all data/address outputs 0; starvation counter 0; timeout counter 0; owner=IF.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE, arbitration:
  - If lsu_req_valid and not (if_req_valid and starve_cnt==STARVE_MAX), grant LSU; else if if_req_valid, grant IF.
  - Grant = combinational ready pulse to the winner in the same cycle.
  - Request fields latched into registers (IF forces wen=0, mask=all ones, wdata=0); owner recorded; go to REQ.
  - No grant: remain in IDLE.
- Starvation counter:
  - Increments on an LSU grant while if_req_valid=1, saturating at STARVE_MAX.
  - Clears on an IF grant, or in any cycle with if_req_valid=0.
- REQ: mem_req_valid=1 with the registered fields. On mem_req_ready go to WAIT, timeout counter=0. Fields stay stable until accepted.
- WAIT:
  - On mem_resp_valid: register mem_rdata into the owner's rdata, err=0; go to RESP.
  - Otherwise the counter increments. When it reaches TIMEOUT_CYC: rdata=0, err=1; go to RESP.
  - mem_resp_valid in the same cycle as the timeout wins (err=0).
- RESP: owner's resp_valid=1 for exactly one cycle, then go to IDLE. rdata holds its value until the next response to that owner.
- Latency: minimum request-to-response is 4 cycles (grant in IDLE, REQ with ready=1, WAIT with resp=1, RESP).
- Only one transaction is outstanding. New requests are not accepted in REQ/WAIT/RESP; ready stays 0.
- mem_resp_valid outside WAIT is ignored.
- Requesters must hold valid and fields stable until ready. Dropping valid before grant is legal and has no effect.
- Asynchronous reset mid-transaction drops the in-flight access with no response; memory is reset by the same rst_n.

Decomposition:
- Shared package holds:
  - state enum: IDLE=2'd0, REQ=2'd1, WAIT=2'd2, RESP=2'd3
  - owner encoding: OWN_IF=1'b0, OWN_LSU=1'b1
  - AW/DW defaults
- One sub-module: ysyx_22050019_mem_arb_pick, holding the grant decision and the starvation counter. Inputs: both valids, idle flag. Outputs: grant_if, grant_lsu.
- FSM, request registers and response routing stay in the top.

Test Plan:
- Single IF fetch:
  - Stimulus: if_addr=0x80000000; memory ready=1, response next cycle, rdata=0x00000413.
  - Required: if_req_ready in cycle 0, mem_addr=0x80000000 with mem_wen=0, if_resp_valid in cycle 3, if_rdata=0x00000413, err=0.
- Collision:
  - Stimulus: IF and LSU store (addr 0x80001000, wdata 0xDEADBEEF, mask 0x0F) valid in the same cycle.
  - Required: LSU granted first, mem_mask=0x0F; IF granted in the IDLE after the LSU response.
- Starvation guard:
  - Stimulus: IF and LSU continuously valid, STARVE_MAX=4.
  - Required: grant order LSU,LSU,LSU,LSU,IF, then the pattern repeats.
- Stall:
  - Stimulus: mem_req_ready held 0 for 5 cycles.
  - Required: mem_req_valid and fields stable, no other grant, response after ready rises.
- Timeout:
  - Stimulus: TIMEOUT_CYC=8, no mem_resp_valid.
  - Required: lsu_resp_valid with lsu_resp_err=1 and lsu_rdata=0 eight cycles after WAIT entry; a late mem_resp_valid is ignored.
- Reset in WAIT:
  - Stimulus: rst_n low for 1 cycle.
  - Required: all outputs 0 immediately, state IDLE, no response pulse; next request served normally.
